// File: rtl/rev_arb_ctrl.sv
// Round-robin arbiter fronting a shared fixed-latency reversal resource.
// One transaction at a time: grant, capture pulse, wait LAT cycles, hold response until accepted.
module rev_arb_ctrl #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    parameter int LAT   = 1,
    localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*WIDTH-1:0] i_req_data,
    output logic [N_REQ-1:0]       o_gnt,
    output logic                   o_en,
    output logic [WIDTH-1:0]       o_a,
    input  logic [WIDTH-1:0]       i_res,
    output logic                   o_rsp_valid,
    output logic [WIDTH-1:0]       o_rsp_data,
    output logic [IDW-1:0]         o_rsp_id,
    input  logic                   i_rsp_ready,
    output logic                   o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     owner;
    logic [3:0]         wait_cnt;
    logic               found;
    logic [IDW-1:0]     win;
    logic [WIDTH-1:0]   win_data;
    logic [N_REQ-1:0]   gnt;
    logic               en;
    logic [WIDTH-1:0]   opnd;
    logic               rsp_valid;
    logic [WIDTH-1:0]   rsp_data;
    logic [IDW-1:0]     rsp_id;
    logic               busy;

    // Index reached by stepping off places from base, wrapping at N_REQ.
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end else begin
            s = s;
        end
        return IDW'(s);
    endfunction

    // Round-robin search starting at ptr; first set request wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && i_req[rr_idx(ptr, i)]) begin
                found = 1'b1;
                win   = rr_idx(ptr, i);
            end else begin
                found = found;
            end
        end
        win_data = i_req_data[win*WIDTH +: WIDTH];
    end

    // Transaction sequencing.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    next_state = ST_CAPTURE;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_CAPTURE: next_state = ST_WAIT;
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    next_state = ST_RESP;
                end else begin
                    next_state = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    next_state = ST_IDLE;
                end else begin
                    next_state = ST_RESP;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath and registered outputs; grant/enable are single-cycle pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr       <= '0;
            owner     <= '0;
            wait_cnt  <= 4'd0;
            gnt       <= '0;
            en        <= 1'b0;
            opnd      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            busy      <= 1'b0;
        end else begin
            gnt  <= '0;
            en   <= 1'b0;
            busy <= (next_state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        owner <= win;
                        opnd  <= win_data;
                        gnt   <= N_REQ'(1'b1) << win;
                        en    <= 1'b1;
                        ptr   <= rr_idx(win, 1);
                    end
                end
                ST_CAPTURE: begin
                    wait_cnt <= 4'(LAT - 1);
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        rsp_data  <= i_res;
                        rsp_id    <= owner;
                        rsp_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_gnt       = gnt;
    assign o_en        = en;
    assign o_a         = opnd;
    assign o_rsp_valid = rsp_valid;
    assign o_rsp_data  = rsp_data;
    assign o_rsp_id    = rsp_id;
    assign o_busy      = busy;

endmodule

// File: tb/tb_rev_arb_ctrl.sv
// Directed bench for rev_arb_ctrl: a LAT=1 instance for arbitration/backpressure/reset
// and a LAT=3 instance for result-sampling timing, each fed by a bit-reversal resource model.
module tb_rev_arb_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          failures = 0;

    logic [3:0]  req = 4'd0;
    logic [15:0] req_data = 16'd0;
    logic [3:0]  gnt;
    logic        en;
    logic [3:0]  a;
    logic [3:0]  res;
    logic        rsp_valid;
    logic [3:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_ready = 1'b0;
    logic        busy;

    logic [3:0]  req3 = 4'd0;
    logic [15:0] req_data3 = 16'd0;
    logic [3:0]  gnt3;
    logic        en3;
    logic [3:0]  a3;
    logic [3:0]  res3;
    logic        rsp_valid3;
    logic [3:0]  rsp_data3;
    logic [1:0]  rsp_id3;
    logic        rsp_ready3 = 1'b0;
    logic        busy3;

    logic        en_d1 = 1'b0;
    logic [3:0]  a_d1 = 4'd0;
    logic [2:0]  en_p3 = 3'd0;
    logic [3:0]  a_p3 [3];

    always #5 clk = ~clk;

    rev_arb_ctrl #(.N_REQ(4), .WIDTH(4), .LAT(1)) u1 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_data(req_data), .o_gnt(gnt),
        .o_en(en), .o_a(a), .i_res(res), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
        .o_rsp_id(rsp_id), .i_rsp_ready(rsp_ready), .o_busy(busy)
    );

    rev_arb_ctrl #(.N_REQ(4), .WIDTH(4), .LAT(3)) u3 (
        .i_clk(clk), .i_rst(rst), .i_req(req3), .i_req_data(req_data3), .o_gnt(gnt3),
        .o_en(en3), .o_a(a3), .i_res(res3), .o_rsp_valid(rsp_valid3), .o_rsp_data(rsp_data3),
        .o_rsp_id(rsp_id3), .i_rsp_ready(rsp_ready3), .o_busy(busy3)
    );

    function automatic logic [3:0] rev4(input logic [3:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

    // Resource models: reversed operand appears exactly LAT cycles after the enable cycle, 4'b0110 otherwise.
    always @(posedge clk) begin
        en_d1    <= en;
        a_d1     <= rev4(a);
        en_p3    <= {en_p3[1:0], en3};
        a_p3[0]  <= rev4(a3);
        a_p3[1]  <= a_p3[0];
        a_p3[2]  <= a_p3[1];
    end
    assign res  = en_d1 ? a_d1 : 4'b0110;
    assign res3 = en_p3[2] ? a_p3[2] : 4'b0110;

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=%b", gnt, 4'b0000); end
        checks++; if (en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=%b", en, 1'b0); end
        checks++; if (a !== 4'b0000) begin failures++; $display("FAIL reset_a got=%b exp=%b", a, 4'b0000); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=%b", rsp_valid, 1'b0); end
        checks++; if (rsp_data !== 4'b0000) begin failures++; $display("FAIL reset_data got=%b exp=%b", rsp_data, 4'b0000); end
        checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=%0d", rsp_id, 0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=%b", busy, 1'b0); end
        rst = 1'b0;
    endtask

    task automatic test_single;
        req = 4'b0100; req_data = 16'hA3C5;
        @(negedge clk);
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=%b", gnt, 4'b0100); end
        checks++; if (en !== 1'b1) begin failures++; $display("FAIL single_en got=%b exp=%b", en, 1'b1); end
        checks++; if (a !== 4'b0011) begin failures++; $display("FAIL single_a got=%b exp=%b", a, 4'b0011); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=%b", busy, 1'b1); end
        req = 4'b0000; req_data = 16'hFFFF;
        @(negedge clk);
        checks++; if (en !== 1'b0 || gnt !== 4'b0000) begin failures++; $display("FAIL single_wait_pulse got en=%b gnt=%b exp en=0 gnt=0000", en, gnt); end
        checks++; if (a !== 4'b0011) begin failures++; $display("FAIL single_a_hold got=%b exp=%b", a, 4'b0011); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=%b", rsp_valid, 1'b0); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=%b", rsp_valid, 1'b1); end
        checks++; if (rsp_data !== 4'b1100) begin failures++; $display("FAIL single_data got=%b exp=%b", rsp_data, 4'b1100); end
        checks++; if (rsp_id !== 2'd2) begin failures++; $display("FAIL single_id got=%0d exp=%0d", rsp_id, 2); end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_done got valid=%b busy=%b exp 0 0", rsp_valid, busy); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        req = 4'b1000; req_data = 16'hA00B;
        @(negedge clk);
        checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL bp_gnt got=%b exp=%b", gnt, 4'b1000); end
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== 4'b0101 || rsp_id !== 2'd3) begin
                failures++; $display("FAIL bp_hold[%0d] got valid=%b data=%b id=%0d exp 1 0101 3", i, rsp_valid, rsp_data, rsp_id); end
            checks++; if (gnt !== 4'b0000 || en !== 1'b0 || busy !== 1'b1) begin
                failures++; $display("FAIL bp_quiet[%0d] got gnt=%b en=%b busy=%b exp 0000 0 1", i, gnt, en, busy); end
            if (i == 4) rsp_ready = 1'b1;
            @(negedge clk);
        end
        checks++; if (rsp_valid !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0) begin
            failures++; $display("FAIL bp_idle_gap got valid=%b gnt=%b busy=%b exp 0 0000 0", rsp_valid, gnt, busy); end
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001 || a !== 4'b1011) begin failures++; $display("FAIL bp_next_gnt got gnt=%b a=%b exp 0001 1011", gnt, a); end
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        checks++; if (rsp_data !== 4'b1101 || rsp_id !== 2'd0) begin failures++; $display("FAIL bp_next_rsp got data=%b id=%0d exp 1101 0", rsp_data, rsp_id); end
        rsp_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_w [5];
        logic [3:0] exp_a [4];
        logic [3:0] exp_r [4];
        exp_w = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_r = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req = 4'b1111; req_data = 16'h8421; rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (gnt !== (4'b0001 << exp_w[k]) || a !== exp_a[exp_w[k]]) begin
                failures++; $display("FAIL rr_gnt[%0d] got gnt=%b a=%b exp winner %0d", k, gnt, a, exp_w[k]); end
            @(negedge clk);
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_r[exp_w[k]] || rsp_id !== exp_w[k]) begin
                failures++; $display("FAIL rr_rsp[%0d] got valid=%b data=%b id=%0d exp 1 %b %0d", k, rsp_valid, rsp_data, rsp_id, exp_r[exp_w[k]], exp_w[k]); end
            @(negedge clk);
            checks++; if (gnt !== 4'b0000 || rsp_valid !== 1'b0) begin
                failures++; $display("FAIL rr_gap[%0d] got gnt=%b valid=%b exp 0000 0", k, gnt, rsp_valid); end
            if (k == 4) req = 4'b0000;
        end
    endtask

    task automatic test_wrap;
        logic [3:0] reqs [3];
        logic [1:0] exp_w [3];
        logic [3:0] exp_r [4];
        reqs  = '{4'b0100, 4'b0011, 4'b0011};
        exp_w = '{2'd2, 2'd0, 2'd1};
        exp_r = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        for (int k = 0; k < 3; k++) begin
            req = reqs[k];
            @(negedge clk);
            checks++; if (gnt !== (4'b0001 << exp_w[k])) begin failures++; $display("FAIL wrap_gnt[%0d] got=%b exp winner %0d", k, gnt, exp_w[k]); end
            req = 4'b0000;
            @(negedge clk);
            @(negedge clk);
            checks++; if (rsp_id !== exp_w[k] || rsp_data !== exp_r[exp_w[k]]) begin
                failures++; $display("FAIL wrap_rsp[%0d] got id=%0d data=%b exp %0d %b", k, rsp_id, rsp_data, exp_w[k], exp_r[exp_w[k]]); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_wait;
        req = 4'b0010;
        @(negedge clk);
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL rmw_pre_gnt got=%b exp=%b", gnt, 4'b0010); end
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b1; req = 4'b1000;
        @(negedge clk);
        checks++; if (gnt !== 4'b0000 || en !== 1'b0 || a !== 4'b0000 || busy !== 1'b0) begin
            failures++; $display("FAIL rmw_ctrl got gnt=%b en=%b a=%b busy=%b exp all zero", gnt, en, a, busy); end
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 4'b0000 || rsp_id !== 2'd0) begin
            failures++; $display("FAIL rmw_rsp got valid=%b data=%b id=%0d exp all zero", rsp_valid, rsp_data, rsp_id); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (gnt !== 4'b1000 || a !== 4'b1000) begin failures++; $display("FAIL rmw_gnt got gnt=%b a=%b exp 1000 1000", gnt, a); end
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 4'b0001 || rsp_id !== 2'd3) begin
            failures++; $display("FAIL rmw_rsp_after got valid=%b data=%b id=%0d exp 1 0001 3", rsp_valid, rsp_data, rsp_id); end
        @(negedge clk);
    endtask

    task automatic test_lat3;
        req3 = 4'b0001; req_data3 = 16'h0003;
        @(negedge clk);
        checks++; if (en3 !== 1'b1 || a3 !== 4'b0011 || gnt3 !== 4'b0001) begin
            failures++; $display("FAIL lat3_cap got en=%b a=%b gnt=%b exp 1 0011 0001", en3, a3, gnt3); end
        req3 = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (rsp_valid3 !== 1'b0 || busy3 !== 1'b1) begin
                failures++; $display("FAIL lat3_wait[%0d] got valid=%b busy=%b exp 0 1", i, rsp_valid3, busy3); end
        end
        @(negedge clk);
        checks++; if (rsp_valid3 !== 1'b1 || rsp_data3 !== 4'b1100 || rsp_id3 !== 2'd0) begin
            failures++; $display("FAIL lat3_rsp got valid=%b data=%b id=%0d exp 1 1100 0", rsp_valid3, rsp_data3, rsp_id3); end
        rsp_ready3 = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid3 !== 1'b0 || busy3 !== 1'b0) begin failures++; $display("FAIL lat3_done got valid=%b busy=%b exp 0 0", rsp_valid3, busy3); end
        rsp_ready3 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_round_robin();
        test_wrap();
        test_reset_mid_wait();
        test_lat3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rev_arb_ctrl.md
REV_ARB_CTRL -- requirements
Module: rev_arb_ctrl

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters sharing the reversal resource.
REQ-002 Parameter: WIDTH, 4, data width of the shared resource.
REQ-003 Parameter: LAT, 1, cycles from capture-enable pulse to valid resource result (range 1..15).
REQ-004 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  reset; synchronous, active-high.
REQ-006 i_req  input  N_REQ  per-requester request, level, held until granted.
REQ-007 i_req_data  input  N_REQ*WIDTH  per-requester operand; slice k = bits [k*WIDTH +: WIDTH].
REQ-008 o_gnt  output  N_REQ  one-hot grant pulse, one cycle.
REQ-009 o_en  output  1  capture enable to the shared resource.
REQ-010 o_a  output  WIDTH  operand driven to the shared resource.
REQ-011 i_res  input  WIDTH  result returned by the shared resource.
REQ-012 o_rsp_valid  output  1  response valid.
REQ-013 o_rsp_data  output  WIDTH  sampled resource result.
REQ-014 o_rsp_id  output  clog2(N_REQ)  index of requester owning the response.
REQ-015 i_rsp_ready  input  1  consumer accepts response.
REQ-016 o_busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states IDLE, CAPTURE, WAIT, RESP; exactly one transaction in flight.
REQ-018 IDLE: if any i_req bit set, select winner by round-robin, go to CAPTURE; else remain IDLE.
REQ-019 Round-robin: search starts at pointer ptr, wraps N_REQ-1 -> 0; first set bit wins.
REQ-020 On grant, ptr <= winner+1 modulo N_REQ; ptr unchanged when no grant.
REQ-021 Winner index and its i_req_data slice registered on IDLE->CAPTURE transition; later changes to i_req_data ignored.
REQ-022 CAPTURE (exactly one cycle): o_en=1, o_a=registered operand, o_gnt one-hot at winner; go to WAIT.
REQ-023 o_en and o_gnt zero in all other states; o_a holds registered operand outside CAPTURE (zero after reset until first grant).
REQ-024 WAIT: down-counter loaded with LAT-1 on entering; when counter is 0, sample i_res into o_rsp_data, go to RESP.
REQ-025 LAT=1: WAIT lasts one cycle, i.e. i_res sampled in the cycle after CAPTURE.
REQ-026 RESP: o_rsp_valid=1, o_rsp_data and o_rsp_id stable until i_rsp_ready=1 sampled.
REQ-027 RESP with i_rsp_ready=1: transaction completes, go to IDLE; new grant not issued in same cycle (min 1 IDLE cycle between transactions).
REQ-028 i_rsp_ready ignored outside RESP.
REQ-029 Requests arriving or dropping during CAPTURE/WAIT/RESP do not affect current transaction; arbitration evaluated only in IDLE.
REQ-030 Requester must drop i_req after its o_gnt pulse; a still-asserted request re-competes at next IDLE under round-robin.
REQ-031 End-to-end latency, request seen in IDLE to o_rsp_valid: LAT+2 cycles.

Reset
REQ-032 i_rst=1 at a rising edge forces IDLE regardless of current state, including mid-WAIT or mid-RESP; in-flight transaction discarded.
REQ-033 Reset values: o_gnt=0, o_en=0, o_a=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_id=0, o_busy=0, ptr=0, wait counter=0.
REQ-034 i_rst has priority over all other inputs in the same cycle.

Verification
REQ-035 Single request: i_req=4'b0100, slice2=4'b0011, i_res=4'b1100 model, LAT=1 -> o_gnt=4'b0100 in CAPTURE, o_en=1 and o_a=4'b0011 for one cycle, o_rsp_valid two cycles after IDLE sample with o_rsp_data=4'b1100, o_rsp_id=2.
REQ-036 Round-robin fairness: i_req=4'b1111 held, ptr=0, i_rsp_ready=1 -> grant order 0,1,2,3,0.
REQ-037 Wrap-around: ptr=3 (after granting 2), i_req=4'b0011 -> grant 0, then ptr=1.
REQ-038 Backpressure: i_rsp_ready=0 for 5 cycles in RESP -> o_rsp_valid, o_rsp_data, o_rsp_id unchanged, no new o_gnt/o_en, then completes one cycle after i_rsp_ready=1.
REQ-039 LAT=3: i_res sampled exactly 3 cycles after o_en pulse; value presented earlier is not captured.
REQ-040 Reset mid-WAIT: i_rst=1 one cycle -> next cycle all outputs per REQ-033, ptr=0; pending i_req=4'b1000 then granted as grant 3.
